// File: rtl/l2_pkg.sv
// Shared constants and state encoding for the L2 memory-port arbiter.
package l2_pkg;

    localparam int unsigned L2_ADDR_W       = 28;
    localparam int unsigned L2_DATA_W       = 128;
    localparam int unsigned L2_MAX_D_STREAK = 4;

    // Wide enough for MAX_D_STREAK up to 15.
    localparam int unsigned STREAK_W = 4;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_GRANT_I = 2'd1;
    localparam logic [1:0] ARB_GRANT_D = 2'd2;
    localparam logic [1:0] ARB_COOL    = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = ARB_IDLE,
        StGrantI = ARB_GRANT_I,
        StGrantD = ARB_GRANT_D,
        StCool   = ARB_COOL
    } arb_state_e;

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational winner select: D by default, I once the D streak hits its limit.
module l2_arb_pick
    import l2_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = L2_MAX_D_STREAK
) (
    input  logic                i_req_i,
    input  logic                d_req_i,
    input  logic [STREAK_W-1:0] d_streak_i,
    output logic                gnt_i_o,
    output logic                gnt_d_o
);

    logic i_starved;

    assign i_starved = i_req_i && (d_streak_i == STREAK_W'(MAX_D_STREAK));
    assign gnt_d_o   = d_req_i && !i_starved;
    assign gnt_i_o   = i_req_i && !gnt_d_o;

endmodule

// File: rtl/l2_mem_arbiter.sv
// Shares one memory port between the L2 I-cache and D-cache with zero added
// latency when uncontended; a D-grant streak counter prevents I starvation.
module l2_mem_arbiter
    import l2_pkg::*;
#(
    parameter int unsigned ADDR_W       = L2_ADDR_W,
    parameter int unsigned DATA_W       = L2_DATA_W,
    parameter int unsigned MAX_D_STREAK = L2_MAX_D_STREAK
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              arb_busy
);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic i_req, d_req, gnt_i, gnt_d;
    logic fwd_i, fwd_d;
    logic i_ready_c, d_ready_c;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    l2_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .i_req_i    (i_req),
        .d_req_i    (d_req),
        .d_streak_i (streak_q),
        .gnt_i_o    (gnt_i),
        .gnt_d_o    (gnt_d)
    );

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        rdata_d   = rdata_q;
        fwd_i     = 1'b0;
        fwd_d     = 1'b0;
        i_ready_c = 1'b0;
        d_ready_c = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt_d) begin
                    fwd_d   = 1'b1;
                    state_d = StGrantD;
                    if (!i_req) begin
                        streak_d = '0;
                    end else if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (gnt_i) begin
                    fwd_i    = 1'b1;
                    state_d  = StGrantI;
                    streak_d = '0;
                end
            end
            StGrantI: begin
                // A dropped request parks the port idle until memory completes.
                fwd_i = i_req;
                if (mem_ready) begin
                    i_ready_c = 1'b1;
                    rdata_d   = mem_rdata;
                    state_d   = StCool;
                end
            end
            StGrantD: begin
                fwd_d = d_req;
                if (mem_ready) begin
                    d_ready_c = 1'b1;
                    rdata_d   = mem_rdata;
                    state_d   = StCool;
                end
            end
            StCool: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q  <= StIdle;
            streak_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            rdata_q  <= rdata_d;
        end
    end

    // Every output is forced low while reset is held, including the
    // combinational forwarding paths.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (proc_reset_n) begin
            if (fwd_d) begin
                mem_read  = d_read;
                mem_write = d_write;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else if (fwd_i) begin
                mem_read  = 1'b1;
                mem_addr  = i_addr;
            end
        end
    end

    assign i_ready  = proc_reset_n & i_ready_c;
    assign d_ready  = proc_reset_n & d_ready_c;
    assign i_rdata  = !proc_reset_n ? '0 : (i_ready_c ? mem_rdata : rdata_q);
    assign d_rdata  = !proc_reset_n ? '0 : (d_ready_c ? mem_rdata : rdata_q);
    assign arb_busy = proc_reset_n && (state_q != StIdle);

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: reset, lone I read, contention,
// starvation guard, D write forwarding, spurious ready.
module tb_l2_mem_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    localparam logic [ADDR_W-1:0] IA = 28'h0000080;
    localparam logic [ADDR_W-1:0] DA = 28'h0000100;
    localparam logic [DATA_W-1:0] A5 = {16{8'hA5}};

    logic              clk = 1'b0;
    logic              proc_reset_n;
    logic              i_read, d_read, d_write, mem_ready;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [DATA_W-1:0] d_wdata, mem_rdata;
    logic              i_ready, d_ready, mem_read, mem_write, arb_busy;
    logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l2_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_D_STREAK (4)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_ready      (i_ready),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_ready      (d_ready),
        .d_rdata      (d_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .arb_busy     (arb_busy)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        check(tag, {127'b0, got}, {127'b0, exp});
    endtask

    task automatic check_addr(input string tag, input logic [ADDR_W-1:0] got,
                              input logic [ADDR_W-1:0] exp);
        check(tag, {100'b0, got}, {100'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One transaction with both caches requesting continuously; starts settled in IDLE.
    task automatic run_txn(input string tag, input logic exp_i, input logic [DATA_W-1:0] data);
        check_addr({tag, "_addr"}, mem_addr, exp_i ? IA : DA);
        tick();
        mem_ready = 1'b1;
        mem_rdata = data;
        settle();
        check_bit({tag, "_irdy"}, i_ready, exp_i);
        check_bit({tag, "_drdy"}, d_ready, !exp_i);
        tick();
        mem_ready = 1'b0;
        settle();
        check_bit({tag, "_cool_rd"}, mem_read, 1'b0);
        tick();
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        proc_reset_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // Outputs held low during reset even with a request present.
        #2 i_read = 1'b1;
        #1;
        check_bit("rst_mem_read", mem_read, 1'b0);
        check_bit("rst_busy", arb_busy, 1'b0);
        i_read = 1'b0;
        @(negedge clk);
        proc_reset_n = 1'b1;
        tick();
        settle();
        check_bit("idle_busy", arb_busy, 1'b0);
        check_bit("idle_mem_read", mem_read, 1'b0);

        // Lone I read, ready on the third grant cycle.
        i_read = 1'b1;
        i_addr = 28'h0000040;
        settle();
        check_bit("li_mem_read", mem_read, 1'b1);
        check_addr("li_mem_addr", mem_addr, 28'h0000040);
        check_bit("li_mem_write", mem_write, 1'b0);
        tick();
        settle();
        check_bit("li_busy", arb_busy, 1'b1);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = A5;
        settle();
        check_bit("li_irdy", i_ready, 1'b1);
        check("li_rdata", i_rdata, A5);
        check_bit("li_drdy", d_ready, 1'b0);
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        settle();
        check("li_rdata_hold", i_rdata, A5);
        check_bit("li_cool_irdy", i_ready, 1'b0);
        check_bit("li_cool_rd", mem_read, 1'b0);
        i_read = 1'b0;
        tick();
        settle();
        check_bit("li_idle_busy", arb_busy, 1'b0);

        // Contention: D first, I granted two cycles after d_ready.
        i_read = 1'b1; i_addr = IA;
        d_read = 1'b1; d_addr = DA;
        settle();
        check_addr("ct_d_first", mem_addr, DA);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 128'h11;
        settle();
        check_bit("ct_drdy", d_ready, 1'b1);
        check_bit("ct_irdy", i_ready, 1'b0);
        check("ct_drdata", d_rdata, 128'h11);
        check("ct_irdata_held", i_rdata, A5);
        tick();
        mem_ready = 1'b0;
        settle();
        check_bit("ct_cool_rd", mem_read, 1'b0);
        tick();
        d_read = 1'b0;
        settle();
        check_addr("ct_i_addr", mem_addr, IA);
        check_bit("ct_i_rd", mem_read, 1'b1);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 128'h22;
        settle();
        check_bit("ct_i_rdy", i_ready, 1'b1);
        tick();
        mem_ready = 1'b0;
        tick();
        settle();

        // Starvation guard: D D D D I D D D with I pending throughout.
        d_read = 1'b1;
        settle();
        for (int k = 0; k < 8; k++) begin
            run_txn($sformatf("sg%0d", k), (k == 4), DATA_W'(k + 'h30));
        end

        // Fourth D grant after I (a write) saturates the streak; reset mid-grant.
        d_read = 1'b0; d_write = 1'b1;
        d_addr = 28'h1234567; d_wdata = 128'hDEAD_BEEF;
        settle();
        check_bit("rm_mem_write", mem_write, 1'b1);
        tick();
        settle();
        check_bit("rm_grant_write", mem_write, 1'b1);
        proc_reset_n = 1'b0;
        settle();
        check_bit("rm_write_drop", mem_write, 1'b0);
        check_bit("rm_busy", arb_busy, 1'b0);
        check("rm_wdata", mem_wdata, '0);
        @(negedge clk);
        d_write = 1'b0; d_read = 1'b1; d_addr = DA;
        #1 proc_reset_n = 1'b1;
        settle();
        check_bit("rm_post_busy", arb_busy, 1'b0);
        check_addr("rm_streak_clr", mem_addr, DA);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 128'h55;
        settle();
        check_bit("rm_drdy", d_ready, 1'b1);
        tick();
        mem_ready = 1'b0;
        i_read = 1'b0; d_read = 1'b0;
        tick();
        settle();

        // D write forwarding, ready on the second grant cycle.
        d_write = 1'b1; d_addr = 28'h1234567; d_wdata = 128'hDEAD_BEEF;
        settle();
        check_bit("dw_write", mem_write, 1'b1);
        check_bit("dw_read", mem_read, 1'b0);
        check_addr("dw_addr", mem_addr, 28'h1234567);
        check("dw_wdata", mem_wdata, 128'hDEAD_BEEF);
        tick();
        settle();
        check_bit("dw_wait_rdy", d_ready, 1'b0);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 128'h77;
        settle();
        check_bit("dw_drdy", d_ready, 1'b1);
        tick();
        mem_ready = 1'b0;
        d_write = 1'b0;
        tick();
        settle();

        // Spurious ready in IDLE and in COOL.
        mem_ready = 1'b1;
        mem_rdata = {DATA_W{1'b1}};
        settle();
        check_bit("sp_idle_drdy", d_ready, 1'b0);
        check_bit("sp_idle_irdy", i_ready, 1'b0);
        check("sp_idle_rdata", d_rdata, 128'h77);
        tick();
        mem_ready = 1'b0;
        settle();
        check_bit("sp_idle_busy", arb_busy, 1'b0);
        check("sp_idle_rdata2", i_rdata, 128'h77);
        d_read = 1'b1; d_addr = DA;
        tick();
        mem_ready = 1'b1;
        mem_rdata = 128'h88;
        settle();
        check_bit("sp_drdy", d_ready, 1'b1);
        tick();
        mem_rdata = 128'h99;
        d_read = 1'b0;
        settle();
        check_bit("sp_cool_drdy", d_ready, 1'b0);
        check("sp_cool_rdata", d_rdata, 128'h88);
        check_bit("sp_cool_busy", arb_busy, 1'b1);
        tick();
        mem_ready = 1'b0;
        settle();
        check_bit("sp_back_idle", arb_busy, 1'b0);
        check("sp_final_rdata", d_rdata, 128'h88);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
